// File: rtl/dev_arbiter.sv
// Multi-requester arbiter feeding one registered device slot (starvation, opmode priority, round-robin).
// Optional starvation promotion is compiled in with `define DEV_ARBITER_STARVE_EN.
module dev_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   input  logic [19*NUM_REQ-1:0] req_addr_i,
   input  logic [16*NUM_REQ-1:0] req_data_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   output logic                  dev_valid_o,
   output logic [18:0]           dev_addr_o,
   output logic [15:0]           dev_data_o,
   input  logic                  dev_ready_i,
   input  logic                  dev_opmode_i,
   output logic [NUM_REQ-1:0]    grant_o
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic                 dev_valid_r;
   logic [18:0]          dev_addr_r;
   logic [15:0]          dev_data_r;
   logic [NUM_REQ-1:0]   grant_r;
   logic [PTR_W-1:0]     rr_ptr_r;

   logic                 can_load_s;
   logic                 load_s;
   logic                 starve_found_s;
   logic [PTR_W-1:0]     starve_idx_s;
   logic                 rr_found_s;
   logic [PTR_W-1:0]     rr_idx_s;
   logic [PTR_W-1:0]     win_idx_s;
   logic [PTR_W-1:0]     next_ptr_s;
   logic [NUM_REQ-1:0]   win_onehot_s;
   logic [18:0]          win_addr_s;
   logic [15:0]          win_data_s;

   // The slot may take a new beat when empty or when its beat leaves this cycle.
   assign can_load_s = !dev_valid_r || dev_ready_i;
   assign load_s     = reset && can_load_s && (|req_valid_i);

`ifdef DEV_ARBITER_STARVE_EN
   logic [7:0]         wait_cnt_r [NUM_REQ];
   logic [NUM_REQ-1:0] starved_s;

   // Saturating per-requester wait counters.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!reset) begin
            wait_cnt_r[i] <= 8'd0;
         end else if (!req_valid_i[i] || req_ready_o[i]) begin
            wait_cnt_r[i] <= 8'd0;
         end else if (wait_cnt_r[i] != 8'hFF) begin
            wait_cnt_r[i] <= wait_cnt_r[i] + 8'd1;
         end else begin
            wait_cnt_r[i] <= wait_cnt_r[i];
         end
      end
   end

   // Lowest-index starved requester; scanning downward lets the lowest index overwrite.
   always_comb begin
      starve_found_s = 1'b0;
      starve_idx_s   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         starved_s[i] = (wait_cnt_r[i] >= 8'(STARVE_LIMIT));
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i] && starved_s[i]) begin
            starve_found_s = 1'b1;
            starve_idx_s   = PTR_W'(i);
         end else begin
            starve_found_s = starve_found_s;
         end
      end
   end
`else
   assign starve_found_s = 1'b0;
   assign starve_idx_s   = '0;
`endif

   // Round-robin search from rr_ptr; the nearest valid requester is found last.
   always_comb begin
      logic [PTR_W:0] pos_v;
      rr_found_s = 1'b0;
      rr_idx_s   = '0;
      pos_v      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos_v = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
         if (pos_v >= (PTR_W+1)'(NUM_REQ)) begin
            pos_v = pos_v - (PTR_W+1)'(NUM_REQ);
         end else begin
            pos_v = pos_v;
         end
         if (req_valid_i[pos_v[PTR_W-1:0]]) begin
            rr_found_s = 1'b1;
            rr_idx_s   = pos_v[PTR_W-1:0];
         end else begin
            rr_found_s = rr_found_s;
         end
      end
   end

   // Priority: starved, then opmode requester 0, then round-robin.
   always_comb begin
      win_idx_s = '0;
      if (starve_found_s) begin
         win_idx_s = starve_idx_s;
      end else if (dev_opmode_i && req_valid_i[0]) begin
         win_idx_s = '0;
      end else if (rr_found_s) begin
         win_idx_s = rr_idx_s;
      end else begin
         win_idx_s = '0;
      end
   end

   // Winner one-hot and its payload slices.
   always_comb begin
      win_onehot_s = '0;
      win_addr_s   = 19'd0;
      win_data_s   = 16'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx_s == PTR_W'(i)) begin
            win_onehot_s[i] = 1'b1;
            win_addr_s      = req_addr_i[19*i +: 19];
            win_data_s      = req_data_i[16*i +: 16];
         end else begin
            win_onehot_s[i] = 1'b0;
         end
      end
   end

   assign req_ready_o = load_s ? win_onehot_s : '0;
   assign next_ptr_s  = (win_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : (win_idx_s + PTR_W'(1));

   // Output slot and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dev_valid_r <= 1'b0;
         dev_addr_r  <= 19'd0;
         dev_data_r  <= 16'd0;
         grant_r     <= '0;
         rr_ptr_r    <= '0;
      end else if (load_s) begin
         dev_valid_r <= 1'b1;
         dev_addr_r  <= win_addr_s;
         dev_data_r  <= win_data_s;
         grant_r     <= win_onehot_s;
         rr_ptr_r    <= next_ptr_s;
      end else if (dev_valid_r && dev_ready_i) begin
         dev_valid_r <= 1'b0;
         grant_r     <= '0;
      end else begin
         dev_valid_r <= dev_valid_r;
         grant_r     <= grant_r;
      end
   end

   assign dev_valid_o = dev_valid_r;
   assign dev_addr_o  = dev_addr_r;
   assign dev_data_o  = dev_data_r;
   assign grant_o     = grant_r;

endmodule

// File: tb/tb_dev_arbiter.sv
// Directed self-checking bench for dev_arbiter (NUM_REQ=4, STARVE_LIMIT=3).
// Starvation expectations follow `define DEV_ARBITER_STARVE_EN when it is set.
module tb_dev_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [75:0] req_addr;
   logic [63:0] req_data;
   logic [3:0]  req_ready;
   logic        dev_valid;
   logic [18:0] dev_addr;
   logic [15:0] dev_data;
   logic        dev_ready;
   logic        dev_opmode;
   logic [3:0]  grant;

   int tests_run    = 0;
   int tests_failed = 0;

   dev_arbiter #(.NUM_REQ(4), .STARVE_LIMIT(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid_i  (req_valid),
      .req_addr_i   (req_addr),
      .req_data_i   (req_data),
      .req_ready_o  (req_ready),
      .dev_valid_o  (dev_valid),
      .dev_addr_o   (dev_addr),
      .dev_data_o   (dev_data),
      .dev_ready_i  (dev_ready),
      .dev_opmode_i (dev_opmode),
      .grant_o      (grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] op_exp [5];
   logic [3:0] exp_w;

   initial begin
      reset      = 1'b0;
      req_valid  = 4'h0;
      req_addr   = 76'd0;
      req_data   = 64'd0;
      dev_ready  = 1'b0;
      dev_opmode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_addr[19*i +: 19] = 19'(32'h10000 + i);
         req_data[16*i +: 16] = 16'(32'hA000 + i);
      end

      // Reset state, ready held low while in reset
      tick();
      req_valid = 4'hF;
      tick();
      #1;
      chk("rst_ready", req_ready, 4'h0);
      chk("rst_valid", dev_valid, 1'b0);
      chk("rst_grant", grant, 4'h0);
      chk("rst_addr", dev_addr, 19'h0);
      chk("rst_data", dev_data, 16'h0);

      // Single requester, first cycle out of reset
      req_valid            = 4'b0010;
      req_addr[19 +: 19]   = 19'h00123;
      req_data[16 +: 16]   = 16'hBEEF;
      dev_ready            = 1'b1;
      reset                = 1'b1;
      #1;
      chk("single_ready", req_ready, 4'b0010);
      tick();
      req_valid = 4'h0;
      chk("single_valid", dev_valid, 1'b1);
      chk("single_addr", dev_addr, 19'h00123);
      chk("single_data", dev_data, 16'hBEEF);
      chk("single_grant", grant, 4'b0010);
      #1;
      chk("idle_ready", req_ready, 4'h0);
      tick();
      chk("drain_valid", dev_valid, 1'b0);
      chk("drain_grant", grant, 4'h0);
      tick();
      chk("idle_ready_noeffect", dev_valid, 1'b0);

      // Reset while a beat is held under backpressure
      req_addr[19 +: 19] = 19'h10001;
      req_data[16 +: 16] = 16'hA001;
      req_valid = 4'b1000;
      dev_ready = 1'b0;
      tick();
      req_valid = 4'h0;
      chk("mid_valid", dev_valid, 1'b1);
      chk("mid_grant", grant, 4'b1000);
      reset     = 1'b0;
      req_valid = 4'hF;
      #1;
      chk("mid_rst_ready", req_ready, 4'h0);
      tick();
      chk("mid_rst_valid", dev_valid, 1'b0);
      chk("mid_rst_grant", grant, 4'h0);

      // Round-robin after reset: 0,1,2,3,0 back to back
      reset     = 1'b1;
      dev_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_w = 4'b0001 << (k % 4);
         #1;
         chk("rr_ready", req_ready, exp_w);
         tick();
         chk("rr_grant", grant, exp_w);
         chk("rr_valid", dev_valid, 1'b1);
         chk("rr_addr", dev_addr, 19'(32'h10000 + (k % 4)));
      end

      // Backpressure with requester 1 waiting
      req_valid = 4'b0010;
      dev_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_ready", req_ready, 4'h0);
         tick();
         chk("bp_grant", grant, 4'b0001);
         chk("bp_addr", dev_addr, 19'h10000);
         chk("bp_data", dev_data, 16'hA000);
      end
      dev_ready = 1'b1;
      #1;
      chk("bp_rel_ready", req_ready, 4'b0010);
      tick();
      chk("bp_rel_grant", grant, 4'b0010);
      chk("bp_rel_addr", dev_addr, 19'h10001);

      // Drain one cycle, then opmode priority with requesters 0 and 2
      req_valid = 4'h0;
      tick();
      chk("gap_valid", dev_valid, 1'b0);
      for (int k = 0; k < 5; k++) op_exp[k] = 4'b0001;
`ifdef DEV_ARBITER_STARVE_EN
      op_exp[3] = 4'b0100;
`endif
      req_valid  = 4'b0101;
      dev_opmode = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("op_ready", req_ready, op_exp[k]);
         tick();
         chk("op_grant", grant, op_exp[k]);
      end

      // Opmode off: round-robin resumes from pointer 1, picking requester 2
      dev_opmode = 1'b0;
      #1;
      chk("rr_resume_ready", req_ready, 4'b0100);
      tick();
      chk("rr_resume_grant", grant, 4'b0100);
      chk("rr_resume_data", dev_data, 16'hA002);

      // Opmode change leaves a held slot untouched
      req_valid  = 4'h0;
      dev_ready  = 1'b0;
      dev_opmode = 1'b1;
      tick();
      chk("opchg_grant", grant, 4'b0100);
      chk("opchg_addr", dev_addr, 19'h10002);
      chk("opchg_valid", dev_valid, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dev_arbiter.md
DEV_ARBITER -- requirements
Module: dev_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requester ports (2..8).
REQ-002 Parameter STARVE_LIMIT, default 15, is the wait-cycle count that triggers starvation promotion (1..255).
REQ-003 The block SHALL use one clock and a synchronous active-low reset: ports clk and reset, with reset=0 meaning reset.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  sync active-low reset.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_addr_i  in  19*NUM_REQ  per-requester address; slice i = bits [19i+18:19i].
- req_data_i  in  16*NUM_REQ  per-requester data; slice i = bits [16i+15:16i].
- req_ready_o  out  NUM_REQ  per-requester accept, at most one bit high.
- dev_valid_o  out  1  device request valid.
- dev_addr_o  out  19  device address.
- dev_data_o  out  16  device data.
- dev_ready_i  in  1  device accept.
- dev_opmode_i  in  1  device priority mode.
- grant_o  out  NUM_REQ  one-hot owner of the current dev_* beat; all zero when dev_valid_o=0.

Function
REQ-005 A requester transfer occurs when req_valid_i[i] and req_ready_o[i] are both 1; a device transfer occurs when dev_valid_o and dev_ready_i are both 1.
REQ-006 Output stage: one registered slot holding dev_addr_o, dev_data_o and grant_o; dev_* are driven directly from registers, with no combinational path from req_* to dev_*.
REQ-007 Accept condition: the slot can load when dev_valid_o=0, or when dev_valid_o=1 and dev_ready_i=1 in the same cycle (back-to-back transfers, one per cycle sustained).
REQ-008 When the slot can load and any req_valid_i is set, exactly one winner is selected and its req_ready_o is driven high combinationally in that cycle.
REQ-009 The winner's addr/data SHALL appear on dev_* with dev_valid_o=1 the next cycle, a latency of 1.
REQ-010 Once dev_valid_o=1, dev_addr_o, dev_data_o and grant_o SHALL remain stable until a device transfer occurs.
REQ-011 Winner selection, highest rule first:
- (a) starved requesters, lowest index wins;
- (b) if dev_opmode_i=1 and req_valid_i[0]=1, requester 0 wins;
- (c) otherwise round-robin, starting from rr_ptr.
REQ-012 rr_ptr resets to 0 and, after every requester transfer, becomes (winner index + 1) mod NUM_REQ.
REQ-013 A grant under rule (a) or (b) also updates rr_ptr per REQ-012.
REQ-014 Each requester has an 8-bit saturating wait counter:
- increments each cycle that req_valid_i[i]=1 and req_ready_o[i]=0;
- clears on requester i's transfer;
- clears when req_valid_i[i]=0.
REQ-015 Requester i is starved when its counter is greater than or equal to STARVE_LIMIT.
REQ-016 dev_ready_i=1 while dev_valid_o=0 SHALL have no effect.
REQ-017 With no req_valid_i set, the slot drains: dev_valid_o falls the cycle after the device transfer.
REQ-018 A requester that drops req_valid_i before being granted loses no state other than its wait counter.
REQ-019 A change of dev_opmode_i affects selection only; it SHALL NOT affect the occupied slot.

Reset
REQ-020 While reset=0 at a clk edge, the block SHALL clear: dev_valid_o=0, dev_addr_o=0, dev_data_o=0, grant_o=0, rr_ptr=0 and all wait counters to 0.
REQ-021 req_ready_o SHALL be 0 whenever reset=0.
REQ-022 Reset asserted mid-transfer SHALL discard the slot contents with no device transfer completed.
REQ-023 The first accept can occur in the first cycle with reset=1.

Configuration
REQ-024 Macro DEV_ARBITER_STARVE_EN:
- When defined, wait counters and rule (a) are compiled in.
- When undefined, counters are absent, rule (a) never applies, and selection is rules (b) then (c) only.

Verification
REQ-025 Single requester: req_valid_i=4'b0010, addr=19'h00123, data=16'hBEEF, dev_ready_i=1 -> req_ready_o[1]=1 in cycle N; dev_valid_o=1 with dev_addr_o=19'h00123, dev_data_o=16'hBEEF and grant_o=4'b0010 in cycle N+1.
REQ-026 Round-robin: all four valid continuously, dev_ready_i=1, dev_opmode_i=0 -> grant order 0,1,2,3,0 over five consecutive cycles, with no idle cycles.
REQ-027 Backpressure: dev_ready_i=0 for 5 cycles while a beat is held -> dev_* stable, req_ready_o=0 throughout; dev_ready_i=1 -> next winner's beat appears the following cycle.
REQ-028 Opmode priority: dev_opmode_i=1, requesters 0 and 2 valid continuously, rr_ptr=1 -> requester 0 wins every cycle; with DEV_ARBITER_STARVE_EN and STARVE_LIMIT=3, requester 2 is granted on its 4th waiting cycle.
REQ-029 Reset mid-transfer: dev_valid_o=1, dev_ready_i=0, reset=0 for one cycle -> next cycle dev_valid_o=0, grant_o=0; after release, requester 0 wins first under round-robin.
